// File: rtl/ram_arbiter_if.sv
// Requester handshakes plus the RAM strobe bus for ram_arbiter; slave = arbiter side,
// master = requesters together with the RAM (which drives mem_rdata).
interface ram_arbiter_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 6
);
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              gnt0;
    logic              gnt1;
    logic              done0;
    logic              done1;
    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_oe;
    logic              mem_rd_n;
    logic              mem_wr_n;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        output gnt0, gnt1, done0, done1, rdata, mem_addr, mem_wdata, mem_oe,
               mem_rd_n, mem_wr_n, busy
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        input  gnt0, gnt1, done0, done1, rdata, mem_addr, mem_wdata, mem_oe,
               mem_rd_n, mem_wr_n, busy
    );
endinterface

// File: rtl/ram_arbiter.sv
// Two-port arbiter for a single async RAM; read done 3 cycles, write 3+WR_SETUP after grant; requesters hold req until done.
// Round-robin by default; RAM_ARB_FIXED_PRI_EN gives port 0 fixed priority on ties.
module ram_arbiter #(
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 6,
    parameter int WR_SETUP = 1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    ram_arbiter_if.slave  bus
);
    localparam int CNT_W = (WR_SETUP > 1) ? $clog2(WR_SETUP) : 1;

    typedef enum logic [2:0] {
        IDLE, RD_ACC, RD_CAP, WR_SET, WR_STB, WR_HLD, DONE
    } state_t;

    state_t            r_state;
    logic              r_gnt0;
    logic              r_gnt1;
    logic              r_done0;
    logic              r_done1;
    logic              r_oe;
    logic              r_rd_n;
    logic              r_wr_n;
    logic              r_busy;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_any;
    logic              w_pick1;
    logic              w_we;

    assign w_any = bus.req0 | bus.req1;
    assign w_we  = w_pick1 ? bus.we1 : bus.we0;

`ifdef RAM_ARB_FIXED_PRI_EN
    assign w_pick1 = ~bus.req0 & bus.req1;
`else
    logic r_last;

    // On a tie, port 1 wins only if port 0 was served last.
    assign w_pick1 = bus.req1 & (~bus.req0 | ~r_last);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last <= 1'b1;
        end else if (r_state == IDLE && w_any) begin
            r_last <= w_pick1;
        end
    end
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            r_oe    <= 1'b0;
            r_rd_n  <= 1'b1;
            r_wr_n  <= 1'b1;
            r_busy  <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_cnt   <= '0;
        end else begin
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_gnt0 <= ~w_pick1;
                        r_gnt1 <= w_pick1;
                        r_addr <= w_pick1 ? bus.addr1 : bus.addr0;
                        r_busy <= 1'b1;
                        if (w_we) begin
                            r_wdata <= w_pick1 ? bus.wdata1 : bus.wdata0;
                            r_oe    <= 1'b1;
                            r_cnt   <= CNT_W'(WR_SETUP - 1);
                            r_state <= WR_SET;
                        end else begin
                            r_rd_n  <= 1'b0;
                            r_state <= RD_ACC;
                        end
                    end
                end
                RD_ACC: begin
                    r_state <= RD_CAP;
                end
                RD_CAP: begin
                    r_rdata <= bus.mem_rdata;
                    r_rd_n  <= 1'b1;
                    r_state <= DONE;
                end
                WR_SET: begin
                    if (r_cnt == '0) begin
                        r_wr_n  <= 1'b0;
                        r_state <= WR_STB;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                WR_STB: begin
                    r_wr_n  <= 1'b1;
                    r_state <= WR_HLD;
                end
                // Data stays driven one more cycle past the wr_n rising edge.
                WR_HLD: begin
                    r_state <= DONE;
                end
                DONE: begin
                    r_done0 <= r_gnt0;
                    r_done1 <= r_gnt1;
                    r_gnt0  <= 1'b0;
                    r_gnt1  <= 1'b0;
                    r_oe    <= 1'b0;
                    r_rd_n  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.gnt0      = r_gnt0;
    assign bus.gnt1      = r_gnt1;
    assign bus.done0     = r_done0;
    assign bus.done1     = r_done1;
    assign bus.rdata     = r_rdata;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign bus.mem_oe    = r_oe;
    assign bus.mem_rd_n  = r_rd_n;
    assign bus.mem_wr_n  = r_wr_n;
    assign bus.busy      = r_busy;
endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: one instance with WR_SETUP=1 on a modelled RAM, one with WR_SETUP=3.
module tb_ram_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    ram_arbiter_if #(.ADDR_W(4), .DATA_W(6)) ifa ();
    ram_arbiter_if #(.ADDR_W(4), .DATA_W(6)) ifb ();

    ram_arbiter #(.ADDR_W(4), .DATA_W(6), .WR_SETUP(1)) u_dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (ifa)
    );

    ram_arbiter #(.ADDR_W(4), .DATA_W(6), .WR_SETUP(3)) u_dut3 (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (ifb)
    );

    logic [5:0] ram [16];

    assign ifa.mem_rdata = (ifa.mem_rd_n == 1'b0) ? ram[ifa.mem_addr] : 6'h00;
    assign ifb.mem_rdata = 6'h00;

    always @(posedge ifa.mem_wr_n) begin
        if (ifa.mem_oe === 1'b1) ram[ifa.mem_addr] = ifa.mem_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic access(input bit port, input bit we, input logic [3:0] a,
                          input logic [5:0] d, input string tag);
        bit seen;
        seen = 1'b0;
        if (port) begin
            ifa.req1 = 1'b1; ifa.we1 = we; ifa.addr1 = a; ifa.wdata1 = d;
        end else begin
            ifa.req0 = 1'b1; ifa.we0 = we; ifa.addr0 = a; ifa.wdata0 = d;
        end
        for (int c = 0; c < 20 && !seen; c++) begin
            step();
            if ((port ? ifa.done1 : ifa.done0) === 1'b1) seen = 1'b1;
        end
        ifa.req0 = 1'b0;
        ifa.req1 = 1'b0;
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
        step();
    endtask

    logic [3:0] winners;
    logic [3:0] exp_w;
    int         ngr;
    int         ndone;
    int         nrise;
    bit         prev;
    bit         addr_ok;

    initial begin
        for (int i = 0; i < 16; i++) ram[i] = 6'h00;
        ram[3] = 6'h2A;
        ifa.req0 = 0; ifa.req1 = 0; ifa.we0 = 0; ifa.we1 = 0;
        ifa.addr0 = 0; ifa.addr1 = 0; ifa.wdata0 = 0; ifa.wdata1 = 0;
        ifb.req0 = 0; ifb.req1 = 0; ifb.we0 = 0; ifb.we1 = 0;
        ifb.addr0 = 0; ifb.addr1 = 0; ifb.wdata0 = 0; ifb.wdata1 = 0;
        winners = '0;
`ifdef RAM_ARB_FIXED_PRI_EN
        exp_w = 4'b0000;
`else
        exp_w = 4'b1010;
`endif

        // Reset values
        step();
        step();
        chk("reset_ctl", {ifa.gnt0, ifa.gnt1, ifa.done0, ifa.done1, ifa.mem_oe,
                          ifa.mem_rd_n, ifa.mem_wr_n, ifa.busy}, 32'b0000_0110);
        chk("reset_data", {ifa.rdata, ifa.mem_addr, ifa.mem_wdata}, 32'd0);
        rst_n = 1'b1;
        step();

        // Read port 0, addr 3
        ifa.req0 = 1; ifa.we0 = 0; ifa.addr0 = 4'h3;
        step();
        chk("rd_e0_gnt", {ifa.gnt0, ifa.gnt1, ifa.busy}, 32'b101);
        chk("rd_e0_strobes", {ifa.mem_rd_n, ifa.mem_wr_n, ifa.mem_oe}, 32'b010);
        chk("rd_e0_addr", ifa.mem_addr, 32'h3);
        step();
        chk("rd_e1_rd_n", ifa.mem_rd_n, 32'd0);
        step();
        chk("rd_e2_rd_n_done", {ifa.mem_rd_n, ifa.done0}, 32'b10);
        chk("rd_e2_rdata", ifa.rdata, 32'h2A);
        step();
        chk("rd_e3_done", {ifa.done0, ifa.gnt0, ifa.busy}, 32'b100);
        chk("rd_e3_rdata", ifa.rdata, 32'h2A);
        ifa.req0 = 0;
        step();
        chk("rd_e4_quiet", {ifa.done0, ifa.gnt0, ifa.busy}, 32'b000);

        // Write port 1: 6'h15 -> 4'hC
        ifa.req1 = 1; ifa.we1 = 1; ifa.addr1 = 4'hC; ifa.wdata1 = 6'h15;
        step();
        chk("wr_e0", {ifa.gnt1, ifa.mem_oe, ifa.mem_wr_n}, 32'b111);
        chk("wr_e0_wdata", ifa.mem_wdata, 32'h15);
        step();
        chk("wr_e1_wr_n", {ifa.mem_wr_n, ifa.mem_oe}, 32'b01);
        step();
        chk("wr_e2_hold", {ifa.mem_wr_n, ifa.mem_oe, ifa.done1}, 32'b110);
        step();
        chk("wr_e3", {ifa.mem_wr_n, ifa.mem_oe, ifa.done1}, 32'b110);
        step();
        chk("wr_e4_done", {ifa.done1, ifa.mem_oe, ifa.gnt1}, 32'b100);
        ifa.req1 = 0;
        chk("wr_ram_C", ram[12], 32'h15);
        step();
        access(1'b1, 1'b0, 4'hC, 6'h00, "readback");
        chk("readback_rdata", ifa.rdata, 32'h15);

        // Both ports requesting continuously
        ifa.req0 = 1; ifa.we0 = 0; ifa.addr0 = 4'h3;
        ifa.req1 = 1; ifa.we1 = 0; ifa.addr1 = 4'hC;
        prev = 1'b0;
        ngr = 0;
        for (int c = 0; c < 40 && ngr < 4; c++) begin
            step();
            if ((ifa.gnt0 | ifa.gnt1) && !prev) begin
                winners[ngr] = ifa.gnt1;
                ngr++;
                if (ngr == 4) begin
                    ifa.req0 = 0;
                    ifa.req1 = 0;
                end
            end
            prev = ifa.gnt0 | ifa.gnt1;
        end
        chk("arb_grant_count", 32'(ngr), 32'd4);
        for (int k = 0; k < 4; k++) chk($sformatf("arb_winner%0d", k), 32'(winners[k]), 32'(exp_w[k]));
        for (int c = 0; c < 6; c++) step();
        chk("arb_drained", ifa.busy, 32'd0);

        // Write with inputs changed and req dropped after grant
        ifa.req0 = 1; ifa.we0 = 1; ifa.addr0 = 4'h5; ifa.wdata0 = 6'h33;
        step();
        chk("chg_gnt0", ifa.gnt0, 32'd1);
        ifa.addr0 = 4'h9; ifa.wdata0 = 6'h0C; ifa.req0 = 0;
        ndone = 0;
        nrise = 0;
        addr_ok = 1'b1;
        prev = 1'b1;
        for (int c = 0; c < 12; c++) begin
            step();
            if (ifa.done0) ndone++;
            if (ifa.gnt0 && !prev) nrise++;
            if (ifa.gnt0 && ifa.mem_addr != 4'h5) addr_ok = 1'b0;
            prev = ifa.gnt0;
        end
        chk("chg_done_count", 32'(ndone), 32'd1);
        chk("chg_no_regrant", 32'(nrise), 32'd0);
        chk("chg_addr_stable", 32'(addr_ok), 32'd1);
        chk("chg_ram5", ram[5], 32'h33);
        chk("chg_ram9", ram[9], 32'h00);

        // WR_SETUP=3 instance
        ifb.req0 = 1; ifb.we0 = 1; ifb.addr0 = 4'h2; ifb.wdata0 = 6'h07;
        step();
        chk("s3_e0", {ifb.mem_oe, ifb.mem_wr_n}, 32'b11);
        ifb.req0 = 0;
        step();
        step();
        chk("s3_e2_wr_n", ifb.mem_wr_n, 32'd1);
        step();
        chk("s3_e3_wr_n", ifb.mem_wr_n, 32'd0);
        step();
        chk("s3_e4_wr_n", {ifb.mem_wr_n, ifb.mem_oe}, 32'b11);
        step();
        chk("s3_e5_done", ifb.done0, 32'd0);
        step();
        chk("s3_e6_done", ifb.done0, 32'd1);
        step();

        // Reset during the write strobe
        ifa.req1 = 1; ifa.we1 = 1; ifa.addr1 = 4'h7; ifa.wdata1 = 6'h3F;
        step();
        step();
        chk("rst_pre_wr_n", ifa.mem_wr_n, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_ctl", {ifa.gnt0, ifa.gnt1, ifa.done0, ifa.done1, ifa.mem_oe,
                            ifa.mem_rd_n, ifa.mem_wr_n, ifa.busy}, 32'b0000_0110);
        chk("rst_mid_data", {ifa.rdata, ifa.mem_addr, ifa.mem_wdata}, 32'd0);
        ifa.req1 = 0;
        step();
        rst_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (ifa.done1 || ifa.busy) ndone++;
        end
        chk("rst_after_quiet", 32'(ndone), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
